// File: rtl/kick_pkg.sv
// kick_pkg: shared types, default constants and the strength-to-pulse mapping
// for the solenoid kicker controller.
package kick_pkg;

  // Kicker cycle: charge the capacitor, wait a dead-time, fire, let it cool.
  typedef enum logic [1:0] {CHARGE, ARM, FIRE, COOL} kick_state_e;

  localparam int DEF_N_CH      = 2;
  localparam int DEF_STR_W     = 7;
  localparam int DEF_PW_W      = 20;
  localparam int DEF_PW_STEP   = 8192;
  localparam int DEF_PW_MAX    = 1048575;
  localparam int DEF_GUARD_CYC = 64;
  localparam int DEF_COOL_CYC  = 4194303;

  // Saturated pulse width in trigger cycles. The product is formed at 64 bits,
  // which covers STR_W + PW_W for any sane configuration, then clamped.
  function automatic longint unsigned sat_pw(input longint unsigned strength,
                                             input longint unsigned step,
                                             input longint unsigned pw_max);
    longint unsigned prod;
    prod = strength * step;
    return (prod > pw_max) ? pw_max : prod;
  endfunction

endpackage

// File: rtl/kick_if.sv
// kick_if: request/acknowledge bundle between the command decoder (master)
// and the kicker controller (slave).
interface kick_if #(
  parameter int N_CH  = 2,
  parameter int STR_W = 7
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             kick_req;
  logic [CH_W-1:0]  kick_ch;
  logic [STR_W-1:0] kick_strength;
  logic             ready;
  logic             busy;
  logic             kick_done;

  modport master (output kick_req, kick_ch, kick_strength,
                  input  ready, busy, kick_done);
  modport slave  (input  kick_req, kick_ch, kick_strength,
                  output ready, busy, kick_done);
endinterface

// File: rtl/kick_pulse_timer.sv
// kick_pulse_timer: loadable down-counter shared by the ARM, FIRE and COOL
// phases. Load value-1 to get a phase of 'value' cycles; expired flags zero.
module kick_pulse_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);
  logic [W-1:0] cnt;

  // Count down to zero and hold; a load always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (load)       cnt <= value;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/kick_ctrl.sv
// kick_ctrl: solenoid kicker sequencer (CHARGE -> ARM -> FIRE -> COOL).
// Optional feature macro: KICK_IR_GATE_EN -- when defined, a kick is only
// accepted while the ball-present sensor reads high.
module kick_ctrl
  import kick_pkg::*;
#(
  parameter int N_CH      = DEF_N_CH,
  parameter int STR_W     = DEF_STR_W,
  parameter int PW_W      = DEF_PW_W,
  parameter int PW_STEP   = DEF_PW_STEP,
  parameter int PW_MAX    = DEF_PW_MAX,
  parameter int GUARD_CYC = DEF_GUARD_CYC,
  parameter int COOL_CYC  = DEF_COOL_CYC
) (
  input  logic            clk,
  input  logic            rst_n,
  kick_if.slave           kif,
  input  logic            ball_ir,
  input  logic            cap_done,
  output logic            charge_en,
  output logic [N_CH-1:0] trigger
);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CW_C  = $clog2(COOL_CYC + 1);
  localparam int CW_G  = $clog2(GUARD_CYC + 1);
  localparam int CW_CG = (CW_C > CW_G) ? CW_C : CW_G;
  localparam int CNT_W = (PW_W > CW_CG) ? PW_W : CW_CG;

  kick_state_e      state, nstate;
  logic [CH_W-1:0]  ch_q;
  logic [PW_W-1:0]  pw_q, pw_new;
  logic             accept, req_ok, ch_ok, ir_ok;
  logic             tmr_load, tmr_exp;
  logic [CNT_W-1:0] tmr_val;
  logic             cap_s1;
  logic             fire_end;
  logic             ready_q, busy_q, done_q;

  assign ch_ok  = (32'(kif.kick_ch) < 32'(N_CH));
`ifdef KICK_IR_GATE_EN
  assign ir_ok  = ball_ir;
`else
  // Sensor is ignored in this build; any valid request fires.
  assign ir_ok  = 1'b1 | ball_ir;
`endif
  assign req_ok = kif.kick_req && (kif.kick_strength != '0) && ch_ok && ir_ok;
  assign pw_new = PW_W'(sat_pw(64'(kif.kick_strength), 64'(PW_STEP), 64'(PW_MAX)));

  kick_pulse_timer #(.W(CNT_W)) u_tmr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .value   (tmr_val),
    .expired (tmr_exp)
  );

  // Next-state and timer-load decode; each phase preloads the next one's length.
  always_comb begin
    nstate   = state;
    accept   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state)
      CHARGE: if (req_ok) begin
        accept   = 1'b1;
        nstate   = ARM;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(GUARD_CYC - 1);
      end
      ARM: if (tmr_exp) begin
        nstate   = FIRE;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(pw_q) - CNT_W'(1);
      end
      FIRE: if (tmr_exp) begin
        nstate   = COOL;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(COOL_CYC - 1);
      end
      COOL: if (tmr_exp) nstate = CHARGE;
    endcase
  end

  // State register plus the channel/pulse width captured on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CHARGE;
      ch_q  <= '0;
      pw_q  <= '0;
    end else begin
      state <= nstate;
      if (accept) begin
        ch_q <= kif.kick_ch;
        pw_q <= pw_new;
      end
    end
  end

  // Registered outputs. Power-stage drives follow the current state, so the
  // charger and the gate can never overlap; ready is the second flop of the
  // cap_done synchroniser, gated to CHARGE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      charge_en <= 1'b0;
      trigger   <= '0;
      cap_s1    <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      fire_end  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      charge_en <= (state == CHARGE);
      trigger   <= (state == FIRE) ? (N_CH'(1) << ch_q) : '0;
      cap_s1    <= cap_done;
      ready_q   <= (nstate == CHARGE) && cap_s1;
      busy_q    <= (nstate != CHARGE);
      fire_end  <= (state == FIRE) && (nstate == COOL);
      done_q    <= fire_end;
    end
  end

  assign kif.ready     = ready_q;
  assign kif.busy      = busy_q;
  assign kif.kick_done = done_q;
endmodule

// File: doc/kick_ctrl.md
# kick_ctrl

Parametrised solenoid kicker controller for the robot's kick/chip mechanism. It sequences the boost-charger enable and N_CH solenoid trigger outputs through a charge → arm → fire → cool cycle, with per-request strength and channel selection. It sits between the motion/command decoder, which issues kick requests, and the charger and IGBT gate drivers. It replaces the fixed-table, single-channel kicker with a binary strength-to-pulse-width mapping, explicit dead-times and a request/acknowledge handshake.

## Interface
- N_CH, 2: number of solenoid channels (0 = flat kick, 1 = chip).
- STR_W, 7: width of the strength code.
- PW_W, 20: width of the pulse-width counter.
- PW_STEP, 8192: trigger cycles per strength LSB.
- PW_MAX, 1048575: pulse-width saturation limit, in cycles.
- GUARD_CYC, 64: cycles between charge_en falling and trigger rising.
- COOL_CYC, 4194303: cycles with charge_en held low after the trigger falls.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- kick_req  in  1  request, one-cycle pulse or level.
- kick_ch  in  $clog2(N_CH)  channel select, sampled with kick_req.
- kick_strength  in  STR_W  strength code, sampled with kick_req.
- ball_ir  in  1  ball-present sensor, active high.
- cap_done  in  1  charger "capacitor full", asynchronous.
- charge_en  out  1  charger enable.
- trigger  out  N_CH  solenoid gate drives, at most one bit high.
- ready  out  1  high in CHARGE when synchronised cap_done is 1.
- busy  out  1  high in ARM, FIRE and COOL.
- kick_done  out  1  one-cycle pulse on the first COOL cycle.

## Operation
- Reset values:
  - state = CHARGE.
  - charge_en = 0; it rises on the first clock after reset release.
  - trigger = 0; ready = 0; busy = 0; kick_done = 0.
  - All counters are 0.
- cap_done passes through a 2-flop synchroniser before use.
- States:
  - CHARGE: charge_en = 1.
    - A request is accepted when all of these hold: kick_req = 1, kick_strength != 0, kick_ch < N_CH, and the ball gate passes (see Configuration).
    - On acceptance, latch the channel and pw = min(kick_strength * PW_STEP, PW_MAX), then go to ARM.
    - The multiply is computed at STR_W + PW_W bits before saturation.
    - ready is not required to accept; a low-voltage kick is permitted.
  - ARM: charge_en = 0, counting GUARD_CYC cycles, then go to FIRE.
  - FIRE: trigger[ch] = 1 for exactly pw cycles, then go to COOL.
  - COOL: charge_en = 0 for COOL_CYC cycles, then go to CHARGE.
- Requests arriving outside CHARGE are dropped. There is no queue.
- A rejected request in CHARGE has no effect and produces no kick_done.
- If kick_req stays high, the next kick is taken on the first CHARGE cycle after COOL.
- Reset asserted mid-FIRE clears trigger and charge_en asynchronously. This is a safety requirement.

## Timing
- Request sampled high on edge N (state CHARGE):
  - charge_en low from N+1.
  - trigger high on edges N+1+GUARD_CYC through N+GUARD_CYC+pw, inclusive.
  - kick_done high for one cycle at N+1+GUARD_CYC+pw.
  - charge_en high again at N+1+GUARD_CYC+pw+COOL_CYC.
- ready lags cap_done by 2 cycles and is forced 0 outside CHARGE.
- trigger and charge_en are never high in the same cycle.
- All outputs are registered.

## Configuration
- KICK_IR_GATE_EN
  - Defined: acceptance additionally requires ball_ir = 1 on the request cycle.
  - Undefined: ball_ir is ignored and any valid request fires.
  - Default build defines it.

## Structure
- kick_pkg holds:
  - the state enum (CHARGE, ARM, FIRE, COOL);
  - default parameter constants;
  - the function computing saturated pw.
- Sub-module kick_pulse_timer: a loadable down-counter (load, value, expired) instantiated once and shared across ARM, FIRE and COOL.

## Test plan
- Nominal kick: N_CH=2, PW_STEP=4, GUARD_CYC=3, COOL_CYC=10; strength=5, ch=1, ball_ir=1 at edge N.
  - charge_en falls at N+1.
  - trigger=2'b10 for exactly 20 cycles from N+4.
  - kick_done at N+24; charge_en returns at N+34.
- Saturation: PW_MAX=100, strength=127, PW_STEP=8 → trigger pulse is exactly 100 cycles.
- Rejection:
  - strength 0 → no output change.
  - ch=2 with N_CH=2 → no output change.
  - ball_ir=0 with KICK_IR_GATE_EN defined → no output change; the same request fires when the macro is undefined.
- Request during FIRE or COOL: a second kick_req pulse mid-FIRE is dropped; exactly one kick_done is produced.
- Reset mid-FIRE: rst_n low → trigger and charge_en are 0 in the same cycle, without a clock edge; after release the state is CHARGE and charge_en=1 on the next edge.
- Handshake: cap_done toggled asynchronously → ready follows within 2 cycles in CHARGE and is 0 in ARM, FIRE and COOL.
